// File: rtl/addsub_pkg.sv
// Shared constants and FSM state type for the chunked add/subtract unit.
package addsub_pkg;
   localparam logic SUM   = 1'b0;
   localparam logic MINUS = 1'b1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/addsub_slice.sv
// CHUNK-bit ripple adder built from full_adder cells; also exposes the carry
// into its top bit so the caller can form signed overflow on the last slice.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module addsub_slice #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             ctop
);
   logic [CHUNK:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (c[i]),
         .sum  (sum[i]),
         .cout (c[i+1])
      );
   end

   assign cout = c[CHUNK];
   assign ctop = c[CHUNK-1];
endmodule

// File: rtl/addsub_seq.sv
// Sequential add/subtract: one CHUNK-wide slice per clock, LSB first.
// Optional ADDSUB_SAT_EN macro saturates the result on signed overflow.
module addsub_seq
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);
   localparam int N  = WIDTH / CHUNK;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_q, b_q, res_q, res_nxt, out_nxt;
   logic             carry_q, ovf_nxt;
   logic [IW-1:0]    idx;
   logic             accept, last;
   int               base;
   logic [CHUNK-1:0] a_sl, b_sl, s_sum;
   logic             s_cout, s_ctop;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign last      = (idx == IW'(N - 1));

   always_comb begin
      base = int'(idx) * CHUNK;
      a_sl = a_q[base +: CHUNK];
      b_sl = b_q[base +: CHUNK];
   end

   addsub_slice #(.CHUNK(CHUNK)) u_slice (
      .a    (a_sl),
      .b    (b_sl),
      .cin  (carry_q),
      .sum  (s_sum),
      .cout (s_cout),
      .ctop (s_ctop)
   );

   // Final-result view: only meaningful on the last slice, where it is latched.
   always_comb begin
      res_nxt = res_q;
      res_nxt[base +: CHUNK] = s_sum;
      ovf_nxt = s_ctop ^ s_cout;
`ifdef ADDSUB_SAT_EN
      if (ovf_nxt)
         out_nxt = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else
         out_nxt = res_nxt;
`else
      out_nxt = res_nxt;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = CALC;
         CALC:    if (last) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         idx     <= '0;
         out     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
         zero    <= 1'b0;
      end else if (accept) begin
         // Subtraction as a + ~b + 1: invert b here, inject the +1 as carry-in.
         a_q     <= a;
         b_q     <= b ^ {WIDTH{mode == MINUS}};
         carry_q <= (mode == MINUS);
         res_q   <= '0;
         idx     <= '0;
      end else if (state == CALC) begin
         res_q   <= res_nxt;
         carry_q <= s_cout;
         idx     <= idx + 1'b1;
         if (last) begin
            out  <= out_nxt;
            cout <= s_cout;
            ovf  <= ovf_nxt;
            zero <= (out_nxt == '0);
         end
      end
   end
endmodule
